// File: rtl/sys_tx_arbiter.sv
// sys_tx_arbiter
// Shares one UART TX channel between two response sources: register-file read
// data (one byte per frame) and ALU results (two bytes per frame, low byte
// first). Each source has a single-entry buffer. Grants alternate round-robin
// when both sources are waiting. The d_vld/busy handshake is run once per byte.
module sys_tx_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rf_send,
  input  logic [DATA_WIDTH-1:0]   rf_send_data,
  input  logic                    alu_send,
  input  logic [2*DATA_WIDTH-1:0] alu_send_data,
  input  logic                    uart_tx_busy,
  output logic [DATA_WIDTH-1:0]   uart_tx_p_data,
  output logic                    uart_tx_d_vld,
  output logic                    rf_pend,
  output logic                    alu_pend,
  output logic                    drop_err,
  output logic                    tx_err
);

  localparam int DW = DATA_WIDTH;
  localparam int FW = 2 * DATA_WIDTH;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT_DONE
  } state_t;

  state_t          state;
  logic [DW-1:0]   rf_buf;
  logic [FW-1:0]   alu_buf;
  logic            last_grant_alu;
  logic [FW-1:0]   shift_reg;
  logic [1:0]      bytes_left;
  logic [TW-1:0]   timeout_cnt;

  logic            grant_req;
  logic            grant_rf;
  logic            grant_alu;
  logic [FW-1:0]   grant_frame;
  logic            rf_drop;
  logic            alu_drop;

  // Grant decision: an idle channel with a free UART takes a pending frame,
  // alternating against the previous winner when both sources are waiting.
  always_comb begin
    grant_req = (state == IDLE) && !uart_tx_busy && (rf_pend || alu_pend);
    grant_rf  = 1'b0;
    grant_alu = 1'b0;
    if (grant_req) begin
      if (rf_pend && alu_pend) begin
        grant_rf  = last_grant_alu;
        grant_alu = !last_grant_alu;
      end else begin
        grant_rf  = rf_pend;
        grant_alu = alu_pend;
      end
    end
    grant_frame = grant_rf ? {{DW{1'b0}}, rf_buf} : alu_buf;
    rf_drop     = rf_send && rf_pend && !grant_rf;
    alu_drop    = alu_send && alu_pend && !grant_alu;
  end

  // Source buffers: capture into an empty (or just-granted) slot, otherwise
  // keep the old entry and flag the lost send.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_buf   <= '0;
      rf_pend  <= 1'b0;
      alu_buf  <= '0;
      alu_pend <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= rf_drop || alu_drop;

      if (rf_send && !rf_drop) begin
        rf_buf  <= rf_send_data;
        rf_pend <= 1'b1;
      end else if (grant_rf) begin
        rf_pend <= 1'b0;
      end

      if (alu_send && !alu_drop) begin
        alu_buf  <= alu_send_data;
        alu_pend <= 1'b1;
      end else if (grant_alu) begin
        alu_pend <= 1'b0;
      end
    end
  end

  // Frame sequencer: loads the granted frame, presents one byte at a time,
  // waits for the UART to take and finish it, and aborts a byte that is
  // never acknowledged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      last_grant_alu <= 1'b1;
      shift_reg      <= '0;
      bytes_left     <= 2'd0;
      timeout_cnt    <= '0;
      uart_tx_p_data <= '0;
      uart_tx_d_vld  <= 1'b0;
      tx_err         <= 1'b0;
    end else begin
      tx_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_rf || grant_alu) begin
            last_grant_alu <= grant_alu;
            shift_reg      <= grant_frame;
            bytes_left     <= grant_alu ? 2'd2 : 2'd1;
            uart_tx_p_data <= grant_frame[DW-1:0];
            uart_tx_d_vld  <= 1'b1;
            timeout_cnt    <= '0;
            state          <= DRIVE;
          end
        end

        DRIVE: begin
          if (uart_tx_busy) begin
            uart_tx_d_vld <= 1'b0;
            bytes_left    <= bytes_left - 2'd1;
            state         <= WAIT_DONE;
          end else if (timeout_cnt == TW'(ACK_TIMEOUT - 1)) begin
            uart_tx_d_vld <= 1'b0;
            tx_err        <= 1'b1;
            bytes_left    <= 2'd0;
            state         <= IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
          end
        end

        WAIT_DONE: begin
          if (!uart_tx_busy) begin
            if (bytes_left != 2'd0) begin
              shift_reg      <= shift_reg >> DW;
              uart_tx_p_data <= shift_reg[FW-1:DW];
              uart_tx_d_vld  <= 1'b1;
              timeout_cnt    <= '0;
              state          <= DRIVE;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          uart_tx_d_vld <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_tx_arbiter.sv
// tb_sys_tx_arbiter
// Drives both response sources, emulates the UART TX busy behaviour, and
// compares the arbiter outputs against a transaction-level model each cycle.
module tb_sys_tx_arbiter;

  localparam int DW = 8;
  localparam int AT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          rf_send;
  logic [DW-1:0] rf_send_data;
  logic          alu_send;
  logic [2*DW-1:0] alu_send_data;
  logic          uart_tx_busy;
  logic [DW-1:0] uart_tx_p_data;
  logic          uart_tx_d_vld;
  logic          rf_pend;
  logic          alu_pend;
  logic          drop_err;
  logic          tx_err;

  int checks = 0;
  int errors = 0;

  sys_tx_arbiter #(.DATA_WIDTH(DW), .ACK_TIMEOUT(AT)) dut (
    .clk            (clk),
    .reset          (reset),
    .rf_send        (rf_send),
    .rf_send_data   (rf_send_data),
    .alu_send       (alu_send),
    .alu_send_data  (alu_send_data),
    .uart_tx_busy   (uart_tx_busy),
    .uart_tx_p_data (uart_tx_p_data),
    .uart_tx_d_vld  (uart_tx_d_vld),
    .rf_pend        (rf_pend),
    .alu_pend       (alu_pend),
    .drop_err       (drop_err),
    .tx_err         (tx_err)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // UART TX emulator: mode 0 answers a presented byte with busy one cycle
  // later for 10 cycles, mode 1 holds busy high, mode 2 never raises busy.
  int            uart_mode = 0;
  int            busy_left = 0;
  logic [DW-1:0] tx_log [$];

  always @(posedge clk) begin : uart_emu
    logic          vs;
    logic [DW-1:0] pd;
    int            md;
    vs = uart_tx_d_vld;
    pd = uart_tx_p_data;
    md = uart_mode;
    #2;
    case (md)
      1: uart_tx_busy = 1'b1;
      2: begin
        uart_tx_busy = 1'b0;
        busy_left    = 0;
      end
      default: begin
        if (busy_left > 0) begin
          busy_left--;
          uart_tx_busy = (busy_left > 0);
        end else if (vs) begin
          busy_left    = 10;
          uart_tx_busy = 1'b1;
          tx_log.push_back(pd);
        end else begin
          uart_tx_busy = 1'b0;
        end
      end
    endcase
  end

  // Reference model: buffers as flag+data, the active frame as a queue of
  // bytes still to be accepted, and a count of cycles the current byte has
  // been offered.
  logic          m_rf_pend, m_alu_pend;
  logic [DW-1:0] m_rf_data;
  logic [2*DW-1:0] m_alu_data;
  logic          m_last_rf;
  logic [DW-1:0] m_frame [$];
  logic          m_vld, m_waiting, m_tx_err, m_drop;
  logic [DW-1:0] m_pdata;
  int            m_held;
  logic          g_rf, g_alu;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rf_pend = 0; m_alu_pend = 0; m_rf_data = '0; m_alu_data = '0;
      m_last_rf = 0; m_frame.delete(); m_vld = 0; m_waiting = 0;
      m_tx_err = 0; m_drop = 0; m_pdata = '0; m_held = 0;
    end else begin
      g_rf = 0; g_alu = 0; m_tx_err = 0; m_drop = 0;
      if (m_vld) begin
        if (uart_tx_busy) begin
          void'(m_frame.pop_front());
          m_vld = 0;
          m_waiting = 1;
        end else if (m_held == AT) begin
          m_frame.delete();
          m_vld = 0;
          m_tx_err = 1;
        end else begin
          m_held++;
        end
      end else if (m_waiting) begin
        if (!uart_tx_busy) begin
          m_waiting = 0;
          if (m_frame.size() > 0) begin
            m_vld = 1; m_held = 1; m_pdata = m_frame[0];
          end
        end
      end else if (!uart_tx_busy && (m_rf_pend || m_alu_pend)) begin
        g_rf  = (m_rf_pend && m_alu_pend) ? !m_last_rf : m_rf_pend;
        g_alu = !g_rf;
        m_last_rf = g_rf;
        if (g_rf) m_frame.push_back(m_rf_data);
        else begin
          m_frame.push_back(m_alu_data[DW-1:0]);
          m_frame.push_back(m_alu_data[2*DW-1:DW]);
        end
        m_vld = 1; m_held = 1; m_pdata = m_frame[0];
      end
      if (rf_send) begin
        if (m_rf_pend && !g_rf) m_drop = 1;
        else begin m_rf_data = rf_send_data; m_rf_pend = 1; end
      end else if (g_rf) m_rf_pend = 0;
      if (alu_send) begin
        if (m_alu_pend && !g_alu) m_drop = 1;
        else begin m_alu_data = alu_send_data; m_alu_pend = 1; end
      end else if (g_alu) m_alu_pend = 0;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    checkOutput("d_vld", uart_tx_d_vld, m_vld);
    checkOutput("rf_pend", rf_pend, m_rf_pend);
    checkOutput("alu_pend", alu_pend, m_alu_pend);
    checkOutput("drop_err", drop_err, m_drop);
    checkOutput("tx_err", tx_err, m_tx_err);
    if (m_vld || !reset) checkOutput("p_data", uart_tx_p_data, m_pdata);
  end

  task automatic applyStimulus(input logic rs, input logic [DW-1:0] rd,
                               input logic as, input logic [2*DW-1:0] ad);
    rf_send = rs; rf_send_data = rd; alu_send = as; alu_send_data = ad;
    @(posedge clk); #1;
    rf_send = 0; alu_send = 0;
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while (!(!m_vld && !m_waiting && !m_rf_pend && !m_alu_pend && !uart_tx_busy && busy_left == 0)
           && n < limit) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("[TB] FAIL idle_wait actual=timeout expected=idle within %0d cycles", limit);
    end
  endtask

  task automatic waitLog(input int count, input int limit);
    int n = 0;
    while (tx_log.size() < count && n < limit) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("[TB] FAIL log_wait actual=%0d expected=%0d bytes", tx_log.size(), count);
    end
  endtask

  logic [DW-1:0] exp_q [$];

  task automatic checkLog(input string name);
    checkOutput({name, "_len"}, 16'(tx_log.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      checkOutput({name, "_byte"}, tx_log[i], exp_q[i]);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : main
    int lat;
    int hold;
    int vld_cycles;
    rf_send = 0; rf_send_data = '0; alu_send = 0; alu_send_data = '0;
    uart_tx_busy = 0;
    reset = 1;
    #1 reset = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_d_vld", uart_tx_d_vld, 1'b0);
    checkOutput("rst_rf_pend", rf_pend, 1'b0);
    checkOutput("rst_alu_pend", alu_pend, 1'b0);
    checkOutput("rst_p_data", uart_tx_p_data, 8'h00);
    reset = 1;
    @(posedge clk); #1;

    $display("[TB] test 1: single RF byte");
    tx_log.delete();
    applyStimulus(1, 8'hA5, 0, 16'h0);
    checkOutput("t1_rf_pend", rf_pend, 1'b1);
    lat = 1;
    while (!uart_tx_d_vld && lat < 20) begin @(posedge clk); #1; lat++; end
    checkOutput("t1_latency", 16'(lat), 16'd2);
    checkOutput("t1_rf_pend_grant", rf_pend, 1'b0);
    checkOutput("t1_p_data", uart_tx_p_data, 8'hA5);
    waitIdle(200);
    exp_q = '{8'hA5};
    checkLog("t1");

    $display("[TB] test 2: ALU frame low byte first");
    tx_log.delete();
    applyStimulus(0, 8'h00, 1, 16'h1234);
    waitIdle(200);
    exp_q = '{8'h34, 8'h12};
    checkLog("t2");

    $display("[TB] test 3: simultaneous sends and round-robin");
    tx_log.delete();
    applyStimulus(1, 8'h11, 1, 16'hBEEF);
    waitIdle(300);
    exp_q = '{8'h11, 8'hEF, 8'hBE};
    checkLog("t3a");
    tx_log.delete();
    applyStimulus(1, 8'h22, 0, 16'h0);
    waitLog(1, 50);
    applyStimulus(1, 8'h33, 1, 16'hCAFE);
    waitIdle(300);
    exp_q = '{8'h22, 8'hFE, 8'hCA, 8'h33};
    checkLog("t3b");

    $display("[TB] test 4: send into a full buffer");
    uart_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    tx_log.delete();
    applyStimulus(1, 8'h01, 0, 16'h0);
    applyStimulus(1, 8'h02, 0, 16'h0);
    checkOutput("t4_drop_err", drop_err, 1'b1);
    checkOutput("t4_rf_pend", rf_pend, 1'b1);
    @(posedge clk); #1;
    checkOutput("t4_drop_clear", drop_err, 1'b0);
    uart_mode = 0;
    waitIdle(200);
    exp_q = '{8'h01};
    checkLog("t4");

    $display("[TB] test 5: acknowledge timeout");
    uart_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    tx_log.delete();
    applyStimulus(1, 8'h5A, 0, 16'h0);
    applyStimulus(0, 8'h00, 1, 16'h0F0E);
    hold = 0;
    while (uart_tx_d_vld && hold < 100) begin hold++; @(posedge clk); #1; end
    checkOutput("t5_hold", 16'(hold), 16'(AT));
    checkOutput("t5_tx_err", tx_err, 1'b1);
    checkOutput("t5_alu_pend", alu_pend, 1'b1);
    uart_mode = 0;
    waitIdle(300);
    exp_q = '{8'h0E, 8'h0F};
    checkLog("t5");

    $display("[TB] test 6: reset during a frame");
    tx_log.delete();
    applyStimulus(0, 8'h00, 1, 16'hA1B2);
    waitLog(1, 50);
    applyStimulus(1, 8'h77, 0, 16'h0);
    waitLog(2, 50);
    @(posedge clk); #1;
    reset = 0;
    #1;
    checkOutput("t6_d_vld", uart_tx_d_vld, 1'b0);
    checkOutput("t6_rf_pend", rf_pend, 1'b0);
    checkOutput("t6_alu_pend", alu_pend, 1'b0);
    checkOutput("t6_p_data", uart_tx_p_data, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    vld_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (uart_tx_d_vld) vld_cycles++;
    end
    checkOutput("t6_no_vld", 16'(vld_cycles), 16'd0);
    exp_q = '{8'hB2, 8'hA1};
    checkLog("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
